// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin write arbiter feeding the write side of an async FIFO.
// NUM_REQ requesters compete for a single FIFO write port. The grant is combinational
// from req_valid and the registered state. No write is ever issued while fifo_full is high.
// Optional macro FIFO_ARB_BURST_EN lets a granted requester keep the grant for up to
// MAX_BURST consecutive beats. Without the macro, the grant rotates after every beat.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                          wr_clk,
    input  logic                          wr_rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          grant_valid
);

    localparam int ID_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1 || MAX_BURST > 16) begin : g_bad_param
        $error("fifo_wr_arbiter: NUM_REQ must be 2..8 and MAX_BURST 1..16");
    end

    typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] last_id_q, last_id_d;
    logic [ID_W-1:0] base_id;
    logic [ID_W-1:0] pick_id;
    logic            pick_vld;
    logic [ID_W-1:0] gnt_id;
    logic            gnt_vld;
    logic            xfer;

`ifdef FIFO_ARB_BURST_EN
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    logic [ID_W-1:0]  lock_id_q, lock_id_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             lock_hit;

    // A held lock wins outright. A dropped lock re-arbitrates from the lock owner.
    assign lock_hit = (state_q == LOCK) && req_valid[lock_id_q];
    assign base_id  = (state_q == LOCK) ? lock_id_q : last_id_q;
`else
    assign base_id  = last_id_q;
`endif

    // Round-robin search: take the lowest valid index above base_id.
    // If there is none, wrap to the lowest valid index at or below base_id.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && i <= int'(base_id)) begin
                pick_vld = 1'b1;
                pick_id  = ID_W'(i);
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && i > int'(base_id)) begin
                pick_vld = 1'b1;
                pick_id  = ID_W'(i);
            end
        end
    end

    // Final grant selection: a live lock overrides the round-robin pick.
    always_comb begin
        gnt_vld = pick_vld;
        gnt_id  = pick_id;
`ifdef FIFO_ARB_BURST_EN
        if (lock_hit) begin
            gnt_vld = 1'b1;
            gnt_id  = lock_id_q;
        end
`endif
    end

    assign xfer = gnt_vld && !fifo_full;

    // State register: arbitration history and burst lock.
    always_ff @(posedge wr_clk) begin
        if (!wr_rst_n) begin
            state_q    <= IDLE;
            last_id_q  <= ID_W'(NUM_REQ - 1);
`ifdef FIFO_ARB_BURST_EN
            lock_id_q  <= '0;
            beat_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            last_id_q  <= last_id_d;
`ifdef FIFO_ARB_BURST_EN
            lock_id_q  <= lock_id_d;
            beat_cnt_q <= beat_cnt_d;
`endif
        end
    end

    // Next-state logic. Everything is frozen while the FIFO is full.
    always_comb begin
        state_d   = state_q;
        last_id_d = last_id_q;
`ifdef FIFO_ARB_BURST_EN
        lock_id_d  = lock_id_q;
        beat_cnt_d = beat_cnt_q;
        if (!fifo_full) begin
            if (lock_hit) begin
                // Locked beat. The last allowed beat releases the lock.
                if (beat_cnt_q == CNT_W'(MAX_BURST - 1)) begin
                    state_d    = IDLE;
                    last_id_d  = lock_id_q;
                    beat_cnt_d = '0;
                end else begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end else begin
                // The lock owner went away, so release the lock now.
                // The round-robin pick already started after it.
                if (state_q == LOCK) begin
                    state_d    = IDLE;
                    last_id_d  = lock_id_q;
                    beat_cnt_d = '0;
                end
                if (xfer) begin
                    last_id_d = gnt_id;
                    if (MAX_BURST > 1) begin
                        state_d    = LOCK;
                        lock_id_d  = gnt_id;
                        beat_cnt_d = CNT_W'(1);
                    end
                end
            end
        end
`else
        state_d = IDLE;
        if (xfer) begin
            last_id_d = gnt_id;
        end
`endif
    end

    // Output logic. All outputs are forced quiet while reset is held.
    always_comb begin
        req_ready    = '0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = '0;
        grant_id     = '0;
        grant_valid  = 1'b0;
        if (wr_rst_n && gnt_vld) begin
            grant_valid       = 1'b1;
            grant_id          = gnt_id;
            fifo_wr_data      = req_data[int'(gnt_id) * DATA_WIDTH +: DATA_WIDTH];
            fifo_wr_en        = !fifo_full;
            req_ready[gnt_id] = !fifo_full;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter. It covers three things:
// - a table of vectors plus hand sequences for the burst corners;
// - a 3-requester instance that exercises wrap-around;
// - a randomized run scored against a rotation model and per-requester order checks.
module tb_fifo_wr_arbiter;

    localparam int DW = 16;
    localparam int N  = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    valid;
    logic [N*DW-1:0] data;
    logic [N-1:0]    ready;
    logic            full;
    logic            wen;
    logic [DW-1:0]   wdata;
    logic [1:0]      gid;
    logic            gv;

    logic [2:0]  valid3;
    logic [23:0] data3;
    logic [2:0]  ready3;
    logic        full3;
    logic        wen3;
    logic [7:0]  wdata3;
    logic [1:0]  gid3;
    logic        gv3;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .MAX_BURST(4)) dut (
        .wr_clk(clk), .wr_rst_n(rst_n), .req_valid(valid), .req_data(data),
        .req_ready(ready), .fifo_full(full), .fifo_wr_en(wen), .fifo_wr_data(wdata),
        .grant_id(gid), .grant_valid(gv));

    fifo_wr_arbiter #(.DATA_WIDTH(8), .NUM_REQ(3), .MAX_BURST(1)) dut3 (
        .wr_clk(clk), .wr_rst_n(rst_n), .req_valid(valid3), .req_data(data3),
        .req_ready(ready3), .fifo_full(full3), .fifo_wr_en(wen3), .fifo_wr_data(wdata3),
        .grant_id(gid3), .grant_valid(gv3));

    typedef struct {
        logic       rst_n;
        logic [3:0] v;
        logic       f;
        logic       gv;
        logic [1:0] gid;
        logic [3:0] rdy;
        logic       wen;
    } vec_t;

    int tests = 0;
    int fails = 0;
    int seq[N];     // beats each requester has handed over so far
    int rx_exp[N];  // next sequence number expected out of the FIFO per requester

    // Requester i presents i*256 + 0x10 + (number of beats it has already sent).
    function automatic logic [DW-1:0] payload(input int i);
        return DW'(i * 256 + 16 + seq[i]);
    endfunction

    task automatic drive_data();
        for (int i = 0; i < N; i++) data[i*DW +: DW] = payload(i);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference rotation: first valid index after 'last', wrapping modulo n; -1 if none.
    function automatic int m_pick(input logic [3:0] v, input int last, input int n);
        for (int k = 1; k <= n; k++) begin
            int idx;
            idx = (last + k) % n;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic apply(input string nm, input vec_t t);
        rst_n = t.rst_n; valid = t.v; full = t.f;
        @(negedge clk);
        chk({nm, ".gv"}, 32'(gv), 32'(t.gv));
        chk({nm, ".gid"}, 32'(gid), 32'(t.gid));
        chk({nm, ".rdy"}, 32'(ready), 32'(t.rdy));
        chk({nm, ".wen"}, 32'(wen), 32'(t.wen));
        if (!t.gv) chk({nm, ".data0"}, 32'(wdata), 32'h0);
        else if (t.wen) chk({nm, ".data"}, 32'(wdata), 32'(payload(int'(t.gid))));
        @(posedge clk); #1;
        if (t.rst_n && t.wen) seq[t.gid]++;
        drive_data();
    endtask

    task automatic step3(input string nm, input logic r, input logic [2:0] v,
                         input logic egv, input logic [1:0] eg);
        rst_n = r; valid3 = v;
        @(negedge clk);
        chk({nm, ".gv"}, 32'(gv3), 32'(egv));
        chk({nm, ".gid"}, 32'(gid3), 32'(eg));
        chk({nm, ".wen"}, 32'(wen3), 32'(egv));
        chk({nm, ".data"}, 32'(wdata3), egv ? 32'(8'h11 * (eg + 1)) : 32'h0);
        @(posedge clk); #1;
    endtask

    vec_t vt[20];
    vec_t b;

    initial begin
        rst_n = 1'b0; valid = '0; full = 1'b0;
        valid3 = '0; full3 = 1'b0; data3 = {8'h33, 8'h22, 8'h11};
        for (int i = 0; i < N; i++) seq[i] = 0;
        drive_data();

`ifndef FIFO_ARB_BURST_EN
        // Per-beat rotation: reset, full rotation, a full stall on requester 2, dropouts.
        vt[0]  = '{1'b0, 4'hF, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0};
        vt[1]  = '{1'b0, 4'h5, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0};
        vt[2]  = '{1'b1, 4'hF, 1'b0, 1'b1, 2'd0, 4'h1, 1'b1};
        vt[3]  = '{1'b1, 4'hF, 1'b0, 1'b1, 2'd1, 4'h2, 1'b1};
        vt[4]  = '{1'b1, 4'hF, 1'b0, 1'b1, 2'd2, 4'h4, 1'b1};
        vt[5]  = '{1'b1, 4'hF, 1'b0, 1'b1, 2'd3, 4'h8, 1'b1};
        vt[6]  = '{1'b1, 4'hF, 1'b0, 1'b1, 2'd0, 4'h1, 1'b1};
        vt[7]  = '{1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0};
        for (int i = 8; i < 13; i++) vt[i] = '{1'b1, 4'h4, 1'b1, 1'b1, 2'd2, 4'h0, 1'b0};
        vt[13] = '{1'b1, 4'h4, 1'b0, 1'b1, 2'd2, 4'h4, 1'b1};
        vt[14] = '{1'b1, 4'hA, 1'b0, 1'b1, 2'd3, 4'h8, 1'b1};
        vt[15] = '{1'b1, 4'hA, 1'b0, 1'b1, 2'd1, 4'h2, 1'b1};
        vt[16] = '{1'b1, 4'h1, 1'b0, 1'b1, 2'd0, 4'h1, 1'b1};
        vt[17] = '{1'b1, 4'h1, 1'b0, 1'b1, 2'd0, 4'h1, 1'b1};
        vt[18] = '{1'b1, 4'h8, 1'b1, 1'b1, 2'd3, 4'h0, 1'b0};
        vt[19] = '{1'b1, 4'h6, 1'b0, 1'b1, 2'd1, 4'h2, 1'b1};
        for (int i = 0; i < 20; i++) apply($sformatf("vec%0d", i), vt[i]);
`else
        // Two requesters, each bursting MAX_BURST beats in turn.
        b = '{1'b0, 4'h3, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0}; apply("b31.rst", b);
        for (int i = 0; i < 9; i++) begin
            logic [1:0] g;
            g = (i >= 4 && i < 8) ? 2'd1 : 2'd0;
            b = '{1'b1, 4'h3, 1'b0, 1'b1, g, 4'(1 << g), 1'b1};
            apply($sformatf("b31.%0d", i), b);
        end
        // The lock owner drops out mid-burst; requester 3 takes over in the same cycle.
        b = '{1'b0, 4'hA, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0}; apply("b33.rst", b);
        b = '{1'b1, 4'hA, 1'b0, 1'b1, 2'd1, 4'h2, 1'b1}; apply("b33.0", b);
        apply("b33.1", b);
        b = '{1'b1, 4'h8, 1'b0, 1'b1, 2'd3, 4'h8, 1'b1}; apply("b33.drop", b);
        // Reset mid-burst clears the lock, so the next grant restarts at 0.
        b = '{1'b0, 4'h4, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0}; apply("b34.rst", b);
        b = '{1'b1, 4'h4, 1'b0, 1'b1, 2'd2, 4'h4, 1'b1}; apply("b34.0", b);
        apply("b34.1", b);
        b = '{1'b0, 4'h5, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0}; apply("b34.inrst", b);
        apply("b34.inrst2", b);
        b = '{1'b1, 4'h5, 1'b0, 1'b1, 2'd0, 4'h1, 1'b1}; apply("b34.after", b);
`endif

        // Three requesters: index 2 must wrap to 0.
        valid = '0;
        step3("n3.rst", 1'b0, 3'b111, 1'b0, 2'd0);
        step3("n3.a", 1'b1, 3'b111, 1'b1, 2'd0);
        step3("n3.b", 1'b1, 3'b111, 1'b1, 2'd1);
        step3("n3.c", 1'b1, 3'b111, 1'b1, 2'd2);
        step3("n3.wrap", 1'b1, 3'b111, 1'b1, 2'd0);
        step3("n3.d", 1'b1, 3'b101, 1'b1, 2'd2);
        step3("n3.e", 1'b1, 3'b101, 1'b1, 2'd0);
        step3("n3.f", 1'b1, 3'b010, 1'b1, 2'd1);
        valid3 = '0;

        // Randomized run. Each requester's words must leave in issue order with no gaps.
        begin
            int writes, cyc, m_last, mg, id, s;
            logic [3:0] rdy_c, v_c;
            logic [DW-1:0] d_c;
            logic w_c;
            writes = 0; cyc = 0; m_last = N - 1;
            for (int i = 0; i < N; i++) rx_exp[i] = seq[i];
            rst_n = 1'b0; valid = '0; full = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            while (writes < 200 && cyc < 4000) begin
                cyc++;
                valid = 4'($urandom);
                full  = ($urandom_range(0, 3) == 0);
                @(negedge clk);
                mg = m_pick(valid, m_last, N);
`ifndef FIFO_ARB_BURST_EN
                chk("rnd.gv", 32'(gv), 32'(mg >= 0));
                if (mg >= 0) chk("rnd.gid", 32'(gid), 32'(mg));
`endif
                chk("rnd.wen", 32'(wen), 32'(gv && !full));
                chk("rnd.rdy", 32'(ready), wen ? 32'(1 << gid) : 32'h0);
                rdy_c = ready; v_c = valid; w_c = wen; d_c = wdata;
                @(posedge clk); #1;
                if (w_c) begin
                    id = int'(d_c[15:8]);
                    s  = int'(d_c[7:0]) - 16;
                    if (id < N) begin
                        chk($sformatf("rnd.order%0d", id), 32'(s), 32'(rx_exp[id]));
                        rx_exp[id]++;
                    end else begin
                        chk("rnd.id", 32'(id), 32'(N - 1));
                    end
                    writes++;
                end
                for (int i = 0; i < N; i++) if (rdy_c[i] && v_c[i]) seq[i]++;
                if (mg >= 0 && !full) m_last = mg;
                drive_data();
            end
            if (writes < 200) chk("rnd.timeout", 32'(writes), 32'd200);
            for (int i = 0; i < N; i++)
                chk($sformatf("rnd.count%0d", i), 32'(rx_exp[i]), 32'(seq[i]));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
